store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write-back store buffer between the CPU MEM stage and the data memory.
- Stores retire into a small FIFO and drain to memory one per cycle, so the pipeline does not wait on memory writes.
- Loads take priority on the memory's single address port.
- Loads are forwarded from or stalled by buffered stores so they always see program-order data.
- Memory is byte-addressed and big-endian; a 16-bit word occupies Address and Address+1.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, at least 2).
- ADDR_W, 16, address width.
- DATA_W, 16, data width (fixed at 2 bytes for overlap rules).

Ports:
- Clock  in  1  single rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- StoreValid  in  1  CPU store request.
- StoreAddress  in  ADDR_W  store byte address.
- StoreData  in  DATA_W  store data.
- StoreReady  out  1  store accepted this edge when StoreValid && StoreReady.
- LoadValid  in  1  CPU load request.
- LoadAddress  in  ADDR_W  load byte address.
- LoadReady  out  1  LoadData valid this cycle; CPU stalls while LoadValid && !LoadReady.
- LoadData  out  DATA_W  load result (combinational).
- BufferEmpty  out  1  no pending stores.
- MemAddress  out  ADDR_W  to memory Address.
- MemWriteData  out  DATA_W  to memory WriteData.
- MemWrite  out  1  to memory MemWrite.
- MemRead  out  1  to memory MemRead.
- MemReadData  in  DATA_W  from memory ReadData.

Behaviour:
- Storage and reset:
  - Circular FIFO with head/tail pointers and a count of 0..DEPTH.
  - Reset clears head, tail and count to 0; entry contents are don't-care.
  - While Reset=1: StoreReady=0, LoadReady=0, MemWrite=0, MemRead=0; requests are ignored.
  - After reset: BufferEmpty=1, StoreReady=1.
- Store acceptance:
  - StoreReady = (count != DEPTH).
  - No pass-through when full: a store and a drain in the same cycle at count==DEPTH still reject the store.
  - An accepted store is written at the tail on the rising edge; tail advances modulo DEPTH.
- Arbitration on the single memory port:
  - If LoadValid: MemAddress=LoadAddress, MemRead=1, MemWrite=0, no drain.
  - Else if count>0: MemAddress, MemWriteData = head entry, MemWrite=1, MemRead=0; head pops at that edge.
  - Else: MemWrite=0, MemRead=0, MemAddress=0.
- Load hazard check (combinational, valid entries only):
  - Exact hit: entry address == LoadAddress.
  - Partial hit: entry address == LoadAddress+1 or LoadAddress-1, computed modulo 2^ADDR_W (0xFFFF+1 wraps to 0x0000).
  - Any partial hit: LoadReady=0 and the load is held. Because a held load blocks draining, the partial overlap is resolved by dropping MemRead and draining: when LoadValid && partial hit, arbitration drains instead (MemRead=0, MemWrite=1). This repeats until no partial hit remains.
  - Exact hits only: behaviour set by STORE_BUFFER_FORWARD_EN (see Optional Feature).
  - No hit: LoadReady=1, LoadData=MemReadData.
- Simultaneous store and load:
  - The load checks only entries present before the current edge.
  - A same-cycle store to the same address is not visible to that load; the load returns the older value (program order: load before store).
- Count:
  - count_next = count + accepted_store - drained.
  - Accept and drain in the same cycle leaves count unchanged.
- BufferEmpty = (count==0), registered state only.

Optional Feature:
- Macro STORE_BUFFER_FORWARD_EN.
- Defined:
  - An exact hit with no partial hit gives LoadReady=1.
  - LoadData = data of the youngest exact-matching entry (closest to tail).
  - No drain occurs that cycle.
- Undefined:
  - An exact hit is treated like a partial hit: LoadReady=0 and the buffer drains until no entry matches.
  - LoadData is then read from memory.

Decomposition:
- Package store_buffer_pkg:
  - ADDR_W, DATA_W constants.
  - sb_entry_t struct {addr, data}.
  - Pointer width localparam $clog2(DEPTH).
- Sub-module store_buffer_match:
  - Compares LoadAddress against all valid entries.
  - Outputs exact_hit, partial_hit and youngest-hit index, with priority encoding from the tail backwards.
- Top level holds the FIFO, pointers, arbitration and output muxing.

Test Plan:
- Reset, then 4 stores (addr 0,2,4,6; data 0x1111..0x4444) with no loads:
  - StoreReady=1 until count==4; a 5th store is refused with StoreReady=0.
  - MemWrite pulses over 4 cycles in FIFO order; BufferEmpty=1 afterwards.
- Stores to 2 (0x1234) then 2 (0xABCD), load 2 in the next cycle:
  - FORWARD_EN: LoadReady=1 and LoadData=0xABCD in the same cycle.
  - Without the macro: LoadReady=0 for 2 cycles, then LoadData=0xABCD from memory.
- Store at 2, load at 3 (partial overlap):
  - LoadReady=0, MemWrite=1 to addr 2.
  - Next cycle LoadReady=1 and LoadData=memory[3..4].
- Buffer holding a store at 0xFFFF, load at 0x0000:
  - Wrap-around partial hit: stalls until drained.
- Continuous LoadValid to a non-matching address with 2 stores pending:
  - MemWrite stays 0 and the buffer does not drain.
  - LoadValid drops: both stores drain on consecutive cycles.
- Reset asserted mid-drain with count=3:
  - Next cycle count=0, BufferEmpty=1, MemWrite=0.
  - Remaining stores are never written.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared constants, entry type and address-overlap helper for the store buffer.
package store_buffer_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } sb_entry_t;

  // A word covers two bytes, so a store one byte either side of the load overlaps it.
  function automatic logic partialOverlap(addr_t entryAddr, addr_t loadAddr);
    addr_t loadNext;
    addr_t loadPrev;
    loadNext = loadAddr + addr_t'(1);
    loadPrev = loadAddr - addr_t'(1);
    return (entryAddr == loadNext) || (entryAddr == loadPrev);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and memory-side signals of the store buffer; slave is the buffer itself.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic  StoreValid;
  addr_t StoreAddress;
  data_t StoreData;
  logic  StoreReady;
  logic  LoadValid;
  addr_t LoadAddress;
  logic  LoadReady;
  data_t LoadData;
  logic  BufferEmpty;
  addr_t MemAddress;
  data_t MemWriteData;
  logic  MemWrite;
  logic  MemRead;
  data_t MemReadData;

  modport master (
    output StoreValid, StoreAddress, StoreData, LoadValid, LoadAddress, MemReadData,
    input  StoreReady, LoadReady, LoadData, BufferEmpty,
    input  MemAddress, MemWriteData, MemWrite, MemRead
  );

  modport slave (
    input  StoreValid, StoreAddress, StoreData, LoadValid, LoadAddress, MemReadData,
    output StoreReady, LoadReady, LoadData, BufferEmpty,
    output MemAddress, MemWriteData, MemWrite, MemRead
  );

endinterface

// File: rtl/store_buffer_match.sv
// Compares a load address against all valid buffered stores; reports exact and
// partial overlaps and the index of the youngest exact match.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned Depth = DEPTH,
  parameter int unsigned PtrW  = PTR_W
) (
  input  sb_entry_t [Depth-1:0] entries_i,
  input  logic [Depth-1:0]      valid_i,
  input  addr_t                 loadAddress_i,
  input  logic [PtrW-1:0]       tail_i,
  output logic                  exactHit_o,
  output logic                  partialHit_o,
  output logic [PtrW-1:0]       hitIndex_o
);

  logic [PtrW-1:0] slot;

  always_comb begin
    exactHit_o   = 1'b0;
    partialHit_o = 1'b0;
    hitIndex_o   = '0;
    slot         = '0;
    for (int i = 0; i < Depth; i++) begin
      if (valid_i[i] && partialOverlap(entries_i[i].addr, loadAddress_i)) begin
        partialHit_o = 1'b1;
      end
    end
    // Visit slots oldest to youngest ending just behind the tail, so the last hit wins.
    for (int k = Depth; k >= 1; k--) begin
      slot = tail_i - PtrW'(k);
      if (valid_i[slot] && (entries_i[slot].addr == loadAddress_i)) begin
        exactHit_o = 1'b1;
        hitIndex_o = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer between the MEM stage and data memory; store-to-load
// forwarding is enabled by defining STORE_BUFFER_FORWARD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned Depth = DEPTH
) (
  input logic           Clock,
  input logic           Reset,
  store_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  sb_entry_t [Depth-1:0] entriesQ;
  logic [PtrW-1:0]       headQ;
  logic [PtrW-1:0]       tailQ;
  logic [CntW-1:0]       countQ;
  logic [CntW-1:0]       countD;
  logic [Depth-1:0]      valid;
  logic [PtrW-1:0]       offset;

  logic            exactHit;
  logic            partialHit;
  logic [PtrW-1:0] hitIndex;
  logic            loadHazard;
  logic            forwardHit;
  logic            storeReady;
  logic            storeAccept;
  logic            drain;

  // Slot i holds a pending store when it lies within count slots of the head.
  always_comb begin
    valid  = '0;
    offset = '0;
    for (int i = 0; i < Depth; i++) begin
      offset   = PtrW'(i) - headQ;
      valid[i] = CntW'(offset) < countQ;
    end
  end

  store_buffer_match #(
    .Depth (Depth),
    .PtrW  (PtrW)
  ) u_match (
    .entries_i     (entriesQ),
    .valid_i       (valid),
    .loadAddress_i (bus.LoadAddress),
    .tail_i        (tailQ),
    .exactHit_o    (exactHit),
    .partialHit_o  (partialHit),
    .hitIndex_o    (hitIndex)
  );

`ifdef STORE_BUFFER_FORWARD_EN
  assign loadHazard = partialHit;
  assign forwardHit = exactHit && !partialHit;
`else
  assign loadHazard = partialHit || exactHit;
  assign forwardHit = 1'b0;
`endif

  assign storeReady  = !Reset && (countQ != CntW'(Depth));
  assign storeAccept = bus.StoreValid && storeReady;

  // A hazarded load gives up the port so the overlapping stores can drain.
  always_comb begin
    drain            = 1'b0;
    bus.LoadReady    = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.MemAddress   = '0;
    bus.MemWriteData = '0;
    if (!Reset) begin
      bus.LoadReady = !loadHazard;
      if (bus.LoadValid && !loadHazard) begin
        bus.MemRead    = 1'b1;
        bus.MemAddress = bus.LoadAddress;
      end else if (countQ != '0) begin
        drain            = 1'b1;
        bus.MemWrite     = 1'b1;
        bus.MemAddress   = entriesQ[headQ].addr;
        bus.MemWriteData = entriesQ[headQ].data;
      end
    end
  end

  assign bus.StoreReady  = storeReady;
  assign bus.BufferEmpty = (countQ == '0);
  assign bus.LoadData    = forwardHit ? entriesQ[hitIndex].data : bus.MemReadData;

  assign countD = countQ + CntW'(storeAccept) - CntW'(drain);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      if (storeAccept) begin
        tailQ <= tailQ + PtrW'(1);
      end
      if (drain) begin
        headQ <= headQ + PtrW'(1);
      end
      countQ <= countD;
    end
  end

  always_ff @(posedge Clock) begin
    if (storeAccept) begin
      entriesQ[tailQ] <= '{addr: bus.StoreAddress, data: bus.StoreData};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: per-cycle vector table, write scoreboard and a byte-wide
// big-endian memory model; expectations follow STORE_BUFFER_FORWARD_EN when defined.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic Clock;
  logic Reset;

  store_buffer_if sb_bus ();

  store_buffer #(
    .Depth (DEPTH)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (sb_bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [7:0] mem [0:65535];
  assign sb_bus.MemReadData = {mem[sb_bus.MemAddress], mem[sb_bus.MemAddress + 16'd1]};

  typedef struct {
    logic        rst;
    logic        sv;
    logic [15:0] sa;
    logic [15:0] sd;
    logic        lv;
    logic [15:0] la;
    logic        eSr;
    logic        eLr;
    logic        eMw;
    logic        eMr;
    logic [15:0] eMa;
    logic        eEm;
    logic [15:0] eLd;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sbq[$];
  int          checks = 0;
  int          errors = 0;

  function automatic void add(int rst, int sv, int sa, int sd, int lv, int la, int eSr,
                              int eLr, int eMw, int eMr, int eMa, int eEm, int eLd);
    vec_t v;
    v.rst = rst[0];  v.sv  = sv[0];  v.sa  = sa[15:0];  v.sd  = sd[15:0];
    v.lv  = lv[0];   v.la  = la[15:0];
    v.eSr = eSr[0];  v.eLr = eLr[0]; v.eMw = eMw[0];    v.eMr = eMr[0];
    v.eMa = eMa[15:0]; v.eEm = eEm[0]; v.eLd = eLd[15:0];
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic lv, input logic [15:0] la);
    sb_bus.StoreValid   = sv;
    sb_bus.StoreAddress = sa;
    sb_bus.StoreData    = sd;
    sb_bus.LoadValid    = lv;
    sb_bus.LoadAddress  = la;
  endtask

  // Called at the negedge after output checks; commits the write to the memory model.
  task automatic sample_writes(input string tag);
    logic [15:0] wa;
    logic [15:0] wd;
    logic [31:0] e;
    if (sb_bus.MemWrite === 1'b1) begin
      wa = sb_bus.MemAddress;
      wd = sb_bus.MemWriteData;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s unexpected_write: got addr %0h data %0h expected no write", tag, wa, wd);
      end else begin
        e = sbq.pop_front();
        check({tag, " write"}, {wa, wd}, e);
      end
      mem[wa]         = wd[15:8];
      mem[wa + 16'd1] = wd[7:0];
    end
  endtask

  initial begin
    int          stalls;
    logic        got;
    logic [15:0] hsa [3];
    logic [15:0] hsd [3];

    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
    Reset = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    @(posedge Clock);
    #1;

    // rst sv sa sd lv la | StoreReady LoadReady MemWrite MemRead MemAddress Empty LoadData
    add(1, 1, 'h40, 'hDEAD, 1, 'h100,  0, 0, 0, 0, 'h0,   1, 0);
    add(0, 1, 'h0,  'h1111, 1, 'h100,  1, 1, 0, 1, 'h100, 1, 'h0001);
    add(0, 1, 'h2,  'h2222, 1, 'h100,  1, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 1, 'h4,  'h3333, 1, 'h100,  1, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 1, 'h6,  'h4444, 1, 'h100,  1, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 1, 'h8,  'h5555, 1, 'h100,  0, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 1, 'h8,  'h5555, 0, 0,      0, 0, 1, 0, 'h0,   0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 1, 0, 'h2,   0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 1, 0, 'h4,   0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 1, 0, 'h6,   0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 'h0,   1, 0);
    add(0, 1, 'h2,  'h1234, 1, 'h100,  1, 1, 0, 1, 'h100, 1, 'h0001);
    add(0, 1, 'h2,  'hABCD, 1, 'h100,  1, 1, 0, 1, 'h100, 0, 'h0001);
`ifdef STORE_BUFFER_FORWARD_EN
    add(0, 0, 0, 0, 1, 'h2,            1, 1, 0, 1, 'h2,   0, 'hABCD);
    add(0, 0, 0, 0, 0, 0,              1, 0, 1, 0, 'h2,   0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 1, 0, 'h2,   0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 'h0,   1, 0);
`else
    add(0, 0, 0, 0, 1, 'h2,            1, 0, 1, 0, 'h2,   0, 0);
    add(0, 0, 0, 0, 1, 'h2,            1, 0, 1, 0, 'h2,   0, 0);
    add(0, 0, 0, 0, 1, 'h2,            1, 1, 0, 1, 'h2,   1, 'hABCD);
    add(0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 'h0,   1, 0);
`endif
    add(0, 1, 'h2,  'h5566, 1, 'h100,  1, 1, 0, 1, 'h100, 1, 'h0001);
    add(0, 0, 0, 0, 1, 'h3,            1, 0, 1, 0, 'h2,   0, 0);
    add(0, 0, 0, 0, 1, 'h3,            1, 1, 0, 1, 'h3,   1, 'h6633);
    add(0, 1, 'hFFFF, 'h7788, 1, 'h100, 1, 1, 0, 1, 'h100, 1, 'h0001);
    add(0, 0, 0, 0, 1, 'h0,            1, 0, 1, 0, 'hFFFF, 0, 0);
    add(0, 0, 0, 0, 1, 'h0,            1, 1, 0, 1, 'h0,   1, 'h8811);
    add(0, 1, 'h0,  'h9900, 1, 'h100,  1, 1, 0, 1, 'h100, 1, 'h0001);
    add(0, 0, 0, 0, 1, 'hFFFF,         1, 0, 1, 0, 'h0,   0, 0);
    add(0, 0, 0, 0, 1, 'hFFFF,         1, 1, 0, 1, 'hFFFF, 1, 'h7799);
    add(0, 1, 'h10, 'hAAAA, 1, 'h100,  1, 1, 0, 1, 'h100, 1, 'h0001);
    add(0, 1, 'h20, 'hBBBB, 1, 'h100,  1, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 0, 0, 0, 1, 'h100,          1, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 0, 0, 0, 1, 'h100,          1, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 0, 0, 0, 0, 0,              1, 0, 1, 0, 'h10,  0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 1, 0, 'h20,  0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 'h0,   1, 0);
    add(0, 1, 'h30, 'hCCCC, 1, 'h30,   1, 1, 0, 1, 'h30,  1, 'h3031);
    add(0, 0, 0, 0, 0, 0,              1, 0, 1, 0, 'h30,  0, 0);
    add(0, 1, 'h40, 'h1001, 1, 'h100,  1, 1, 0, 1, 'h100, 1, 'h0001);
    add(0, 1, 'h42, 'h1002, 1, 'h100,  1, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 1, 'h44, 'h1003, 1, 'h100,  1, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 1, 'h46, 'h1004, 1, 'h100,  1, 1, 0, 1, 'h100, 0, 'h0001);
    add(0, 0, 0, 0, 0, 0,              0, 0, 1, 0, 'h40,  0, 0);
    add(1, 0, 0, 0, 1, 'h100,          0, 0, 0, 0, 'h0,   0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 'h0,   1, 0);
    add(0, 1, 'h50, 'h2002, 0, 0,      1, 0, 0, 0, 'h0,   1, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 1, 0, 'h50,  0, 0);
    add(0, 0, 0, 0, 0, 0,              1, 0, 0, 0, 'h0,   1, 0);

    foreach (vecs[n]) begin
      vec_t  v;
      string t;
      v = vecs[n];
      t = $sformatf("vec%0d", n);
      Reset = v.rst;
      drive(v.sv, v.sa, v.sd, v.lv, v.la);
      if (v.rst) sbq.delete();
      else if (v.sv && v.eSr) sbq.push_back({v.sa, v.sd});
      @(negedge Clock);
      check({t, " StoreReady"}, 32'(sb_bus.StoreReady), 32'(v.eSr));
      check({t, " MemWrite"}, 32'(sb_bus.MemWrite), 32'(v.eMw));
      check({t, " MemRead"}, 32'(sb_bus.MemRead), 32'(v.eMr));
      check({t, " MemAddress"}, 32'(sb_bus.MemAddress), 32'(v.eMa));
      check({t, " BufferEmpty"}, 32'(sb_bus.BufferEmpty), 32'(v.eEm));
      if (v.lv) check({t, " LoadReady"}, 32'(sb_bus.LoadReady), 32'(v.eLr));
      if (v.lv && v.eLr) check({t, " LoadData"}, 32'(sb_bus.LoadData), 32'(v.eLd));
      sample_writes(t);
      @(posedge Clock);
      #1;
    end

    // Mixed exact and partial overlap: the load waits for every overlapping store.
    Reset  = 1'b0;
    hsa[0] = 16'h0060; hsd[0] = 16'h0F0F;
    hsa[1] = 16'h0060; hsd[1] = 16'h1357;
    hsa[2] = 16'h0061; hsd[2] = 16'h2468;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, hsa[i], hsd[i], 1'b1, 16'h0100);
      sbq.push_back({hsa[i], hsd[i]});
      @(negedge Clock);
      check($sformatf("fill%0d StoreReady", i), 32'(sb_bus.StoreReady), 32'd1);
      sample_writes($sformatf("fill%0d", i));
      @(posedge Clock);
      #1;
    end
    stalls = 0;
    got    = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0060);
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge Clock);
      if (sb_bus.LoadReady === 1'b1) begin
        got = 1'b1;
        check("stall LoadData", 32'(sb_bus.LoadData), 32'h1324);
      end else begin
        stalls++;
      end
      sample_writes($sformatf("stall%0d", n));
      @(posedge Clock);
      #1;
    end
    check("stall ready_seen", 32'(got), 32'd1);
    check("stall cycles", 32'(stalls), 32'd3);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    @(negedge Clock);
    check("final BufferEmpty", 32'(sb_bus.BufferEmpty), 32'd1);
    check("final scoreboard_left", 32'(sbq.size()), 32'(PTR_W - PTR_W));
    sample_writes("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
